// File: rtl/vga_fml_arbiter.sv
// rtl/vga_fml_arbiter.sv - shares the FML port between VGA display fetch and CPU access after a power-up holdoff
// Optional ack timeout abort is compiled in with VGA_FML_TIMEOUT_EN.
module vga_fml_arbiter #(
    parameter int fml_depth      = 25,
    parameter int HOLDOFF_CYCLES = 16777215,
    parameter int CPU_MAX_WAIT   = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 disp_stb_i,
    input  logic [fml_depth-1:0] disp_adr_i,
    output logic [15:0]          disp_dat_o,
    output logic                 disp_ack_o,
    input  logic                 cpu_stb_i,
    input  logic                 cpu_we_i,
    input  logic [1:0]           cpu_sel_i,
    input  logic [fml_depth-1:0] cpu_adr_i,
    input  logic [15:0]          cpu_dat_i,
    output logic [15:0]          cpu_dat_o,
    output logic                 cpu_ack_o,
    output logic [fml_depth-1:0] fml_adr,
    output logic                 fml_stb,
    output logic                 fml_we,
    output logic [1:0]           fml_sel,
    output logic [15:0]          fml_do,
    input  logic                 fml_ack,
    input  logic [15:0]          fml_di,
    output logic                 enabled_o,
    output logic                 timeout_o
);
    localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
    localparam int SW = (CPU_MAX_WAIT > 0) ? $clog2(CPU_MAX_WAIT + 1) : 1;

    typedef enum logic [2:0] {S_HOLD, S_IDLE, S_DISP, S_CPU, S_RESP} state_t;

    state_t        state, state_nxt;
    logic [HW-1:0] hold_cnt;
    logic [SW-1:0] starve_cnt;
    logic          resp_cpu;
    logic          busy;
    logic          abort;
    logic          grant_cpu;
    logic          grant_disp;

    assign busy       = (state == S_DISP) || (state == S_CPU);
    // CPU wins when the display is idle or the CPU has been passed over too often
    assign grant_cpu  = cpu_stb_i && (!disp_stb_i || (starve_cnt == SW'(CPU_MAX_WAIT)));
    assign grant_disp = disp_stb_i && !grant_cpu;
    assign disp_ack_o = (state == S_RESP) && !resp_cpu;
    assign cpu_ack_o  = (state == S_RESP) && resp_cpu;

`ifdef VGA_FML_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    logic [TW-1:0] tmo_cnt;

    assign abort = busy && !fml_ack && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !busy) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
        if (wb_rst_i) begin
            timeout_o <= 1'b0;
        end else if (abort) begin
            timeout_o <= 1'b1;
        end
    end
`else
    assign abort     = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= S_HOLD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_HOLD: if (hold_cnt <= HW'(1)) state_nxt = S_IDLE;
            S_IDLE: begin
                if (grant_cpu) begin
                    state_nxt = S_CPU;
                end else if (grant_disp) begin
                    state_nxt = S_DISP;
                end
            end
            S_DISP, S_CPU: if (fml_ack || abort) state_nxt = S_RESP;
            S_RESP: state_nxt = S_IDLE;
            default: state_nxt = S_HOLD;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            hold_cnt   <= HW'(HOLDOFF_CYCLES);
            starve_cnt <= '0;
            resp_cpu   <= 1'b0;
            enabled_o  <= 1'b0;
            fml_adr    <= '0;
            fml_stb    <= 1'b0;
            fml_we     <= 1'b0;
            fml_sel    <= 2'b00;
            fml_do     <= 16'h0000;
            disp_dat_o <= 16'h0000;
            cpu_dat_o  <= 16'h0000;
        end else begin
            case (state)
                S_HOLD: begin
                    if (hold_cnt <= HW'(1)) begin
                        hold_cnt  <= '0;
                        enabled_o <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - HW'(1);
                    end
                end
                S_IDLE: begin
                    if (grant_cpu) begin
                        fml_adr    <= cpu_adr_i;
                        fml_we     <= cpu_we_i;
                        fml_sel    <= cpu_sel_i;
                        fml_do     <= cpu_dat_i;
                        fml_stb    <= 1'b1;
                        resp_cpu   <= 1'b1;
                        starve_cnt <= '0;
                    end else if (grant_disp) begin
                        fml_adr  <= disp_adr_i;
                        fml_we   <= 1'b0;
                        fml_sel  <= 2'b11;
                        fml_do   <= 16'h0000;
                        fml_stb  <= 1'b1;
                        resp_cpu <= 1'b0;
                        if (cpu_stb_i && (starve_cnt != SW'(CPU_MAX_WAIT))) begin
                            starve_cnt <= starve_cnt + SW'(1);
                        end
                    end
                    if (!cpu_stb_i) begin
                        starve_cnt <= '0;
                    end
                end
                S_DISP, S_CPU: begin
                    if (fml_ack || abort) begin
                        fml_stb <= 1'b0;
                        // an aborted read returns all ones so the requester is never left hanging
                        if (!fml_we) begin
                            if (state == S_CPU) begin
                                cpu_dat_o <= fml_ack ? fml_di : 16'hFFFF;
                            end else begin
                                disp_dat_o <= fml_ack ? fml_di : 16'hFFFF;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
